multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter OPCODE_W, default 6: opcode width, must be >= 6; opcode bits above bit 5 must be zero for a legal opcode.
REQ-002 Parameter ALUOP_W, default 2: aluOp width, must be >= 2; upper bits beyond 2 are zero-filled.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 opcode  in  OPCODE_W  instruction opcode, valid during ID.
REQ-006 aluZero  in  1  ALU zero flag, valid during EX.
REQ-007 memReady  in  1  data-memory completion handshake.
REQ-008 stall  in  1  external freeze request.
REQ-009 stage  out  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=7.
REQ-010 PCWrite, regWrite, memRead, memWrite, memToReg, regDst, push, pop  out  1 each  datapath strobes.
REQ-011 pcSrc  out  2  next-PC source: 00 PC+1, 01 branch target, 10 jump target, 11 stack top.
REQ-012 aluSrc  out  2  ALU B operand: 00 register, 01 sign-ext immediate, 10 zero-ext immediate.
REQ-013 aluOp  out  ALUOP_W  ALU class: 00 add, 01 sub, 10 R-type funct, 11 logic immediate.
REQ-014 illegal  out  1  one-cycle pulse in EX for an undecodable opcode.

Function
REQ-015 The block SHALL be a Moore FSM; outputs depend only on state and the opcode latched on the ID->EX edge.
REQ-016 Opcodes: R 000000, ADDI 001000, SUBI 001001, ANDI 001100, ORI 001101, LW 100011, SW 101011, BEQ 000100, BNE 000101, J 000010, JAL 000011, RET 000001, HALT 111111; all others are illegal.
REQ-017 IF: PCWrite=1, pcSrc=00; next state ID.
REQ-018 ID: latch opcode; HALT -> HALT state, else EX.
REQ-019 EX: R/immediates -> WB; LW/SW -> MEM; BEQ/BNE: PCWrite = aluZero (BEQ) or !aluZero (BNE), pcSrc=01, aluOp=01 -> IF; J: PCWrite=1, pcSrc=10 -> IF; JAL: additionally push=1; RET: PCWrite=1, pop=1, pcSrc=11 -> IF; illegal: illegal=1 -> IF.
REQ-020 MEM: memRead (LW) or memWrite (SW) held every cycle until memReady=1; SW -> IF, LW -> WB on the memReady cycle.
REQ-021 WB: regWrite=1; regDst=1 for R, else 0; memToReg=1 for LW only.
REQ-022 aluSrc: 01 for ADDI/SUBI/LW/SW, 10 for ANDI/ORI, else 00, asserted in EX and MEM.
REQ-023 Latency from IF: branch/jump/illegal 3 cycles; R/immediate 4; SW 4+wait; LW 5+wait.
REQ-024 stall=1: state held; PCWrite, regWrite, memWrite, push, pop, illegal forced 0; memRead, alu controls retain their values.
REQ-025 stall and memReady in the same MEM cycle: stall wins, and the transaction is not considered complete.
REQ-026 HALT is sticky: all strobes 0, stage=7 until reset.

Reset
REQ-027 reset SHALL force stage=IF and latched opcode=0, and drive all strobes, pcSrc, aluSrc, aluOp, and illegal to 0 in the same cycle, overriding stall.
REQ-028 reset mid-MEM SHALL abandon the access; memRead/memWrite are 0 in the following cycle.

Configuration
REQ-029 Macro MUSA_STACK_OPS_EN defined: JAL/RET decoded per REQ-019.
REQ-030 Macro MUSA_STACK_OPS_EN undefined: push/pop tied 0, and JAL/RET decode as illegal.

Structure
REQ-031 Package musa_ctrl_pkg SHALL hold the stage enum, opcode constants, and the pcSrc/aluSrc/aluOp encodings.
REQ-032 Sub-module ctrl_decode SHALL be a combinational opcode-to-instruction-class decoder; the FSM stays in multicycle_control.

Verification
REQ-033 Reset pulse during MEM of LW -> next cycle stage=0, memRead=0, and IF resumes with PCWrite=1.
REQ-034 opcode=000000 -> stages 0,1,2,4; regWrite=1 and regDst=1 in WB; PCWrite=1 only in IF.
REQ-035 LW with memReady low for 3 cycles -> memRead=1 for 4 MEM cycles, then WB with memToReg=1 and regWrite=1.
REQ-036 BEQ with aluZero=1 -> PCWrite=1, pcSrc=01 in EX; BNE with aluZero=1 -> PCWrite=0.
REQ-037 stall=1 for 2 cycles in WB -> stage stays 4 and regWrite=0, then regWrite=1 for exactly one cycle.
REQ-038 opcode=011100 -> illegal=1 for one EX cycle, then IF; opcode=111111 -> stage=7 held; JAL with macro undefined -> illegal=1 and push=0.

Source files
------------

// File: rtl/musa_ctrl_pkg.sv
// Shared encodings for the multicycle controller: stage codes, opcodes,
// datapath select encodings and the decoded instruction-class record.
package musa_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd7
    } stage_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SUBI = 6'b001001;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_RET  = 6'b000001;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [1:0] PC_SRC_INC    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_STACK  = 2'b11;

    localparam logic [1:0] ALU_SRC_REG  = 2'b00;
    localparam logic [1:0] ALU_SRC_SEXT = 2'b01;
    localparam logic [1:0] ALU_SRC_ZEXT = 2'b10;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_LOGIC = 2'b11;

    typedef enum logic [3:0] {
        CLS_ALU,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_BNE,
        CLS_J,
        CLS_JAL,
        CLS_RET,
        CLS_HALT,
        CLS_ILLEGAL
    } insn_class_e;

    typedef struct packed {
        insn_class_e cls;
        logic [1:0]  alu_op;
        logic [1:0]  alu_src;
        logic        reg_dst;
    } ctrl_info_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode-to-instruction-class decoder.
// MUSA_STACK_OPS_EN enables JAL/RET; without it they decode as illegal.
module ctrl_decode
    import musa_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_info_t          info
);

    logic [5:0] op_lo;
    logic       upper_zero;

    assign op_lo      = opcode[5:0];
    assign upper_zero = ((opcode >> 6) == '0);

    always_comb begin
        info = '{cls: CLS_ILLEGAL, alu_op: ALU_OP_ADD, alu_src: ALU_SRC_REG, reg_dst: 1'b0};
        if (upper_zero) begin
            case (op_lo)
                OP_R:    info = '{cls: CLS_ALU, alu_op: ALU_OP_FUNCT, alu_src: ALU_SRC_REG,  reg_dst: 1'b1};
                OP_ADDI: info = '{cls: CLS_ALU, alu_op: ALU_OP_ADD,   alu_src: ALU_SRC_SEXT, reg_dst: 1'b0};
                OP_SUBI: info = '{cls: CLS_ALU, alu_op: ALU_OP_SUB,   alu_src: ALU_SRC_SEXT, reg_dst: 1'b0};
                OP_ANDI: info = '{cls: CLS_ALU, alu_op: ALU_OP_LOGIC, alu_src: ALU_SRC_ZEXT, reg_dst: 1'b0};
                OP_ORI:  info = '{cls: CLS_ALU, alu_op: ALU_OP_LOGIC, alu_src: ALU_SRC_ZEXT, reg_dst: 1'b0};
                OP_LW:   info = '{cls: CLS_LW,  alu_op: ALU_OP_ADD,   alu_src: ALU_SRC_SEXT, reg_dst: 1'b0};
                OP_SW:   info = '{cls: CLS_SW,  alu_op: ALU_OP_ADD,   alu_src: ALU_SRC_SEXT, reg_dst: 1'b0};
                OP_BEQ:  info.cls = CLS_BEQ;
                OP_BNE:  info.cls = CLS_BNE;
                OP_J:    info.cls = CLS_J;
`ifdef MUSA_STACK_OPS_EN
                OP_JAL:  info.cls = CLS_JAL;
                OP_RET:  info.cls = CLS_RET;
`endif
                OP_HALT: info.cls = CLS_HALT;
                default: info.cls = CLS_ILLEGAL;
            endcase
        end
        if (info.cls == CLS_BEQ || info.cls == CLS_BNE) begin
            info.alu_op = ALU_OP_SUB;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore multicycle control FSM (IF/ID/EX/MEM/WB/HALT) with external stall.
// MUSA_STACK_OPS_EN enables JAL push / RET pop strobes.
module multicycle_control
    import musa_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                aluZero,
    input  logic                memReady,
    input  logic                stall,
    output logic [2:0]          stage,
    output logic                PCWrite,
    output logic                regWrite,
    output logic                memRead,
    output logic                memWrite,
    output logic                memToReg,
    output logic                regDst,
    output logic                push,
    output logic                pop,
    output logic [1:0]          pcSrc,
    output logic [1:0]          aluSrc,
    output logic [ALUOP_W-1:0]  aluOp,
    output logic                illegal
);

    stage_e              state_q, state_d;
    logic [OPCODE_W-1:0] opc_q, opc_d;
    ctrl_info_t          info;
    logic                live_halt;

    logic pc_write, reg_write, mem_read, mem_write, mem_to_reg, reg_dst;
    logic push_c, pop_c, illegal_c;
    logic [1:0] pc_src, alu_src, alu_op;

    // Decodes the opcode latched on the ID->EX edge, never the live input.
    ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .opcode (opc_q),
        .info   (info)
    );

    assign live_halt = (opcode == OPCODE_W'(OP_HALT));

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        if (!stall) begin
            case (state_q)
                ST_IF: state_d = ST_ID;
                ST_ID: begin
                    opc_d   = opcode;
                    state_d = live_halt ? ST_HALT : ST_EX;
                end
                ST_EX: begin
                    case (info.cls)
                        CLS_ALU:        state_d = ST_WB;
                        CLS_LW, CLS_SW: state_d = ST_MEM;
                        default:        state_d = ST_IF;
                    endcase
                end
                ST_MEM: begin
                    if (memReady) begin
                        state_d = (info.cls == CLS_LW) ? ST_WB : ST_IF;
                    end
                end
                ST_WB:   state_d = ST_IF;
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_IF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IF;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        push_c     = 1'b0;
        pop_c      = 1'b0;
        illegal_c  = 1'b0;
        pc_src     = PC_SRC_INC;
        alu_src    = ALU_SRC_REG;
        alu_op     = ALU_OP_ADD;
        case (state_q)
            ST_IF: pc_write = 1'b1;
            ST_EX: begin
                alu_src = info.alu_src;
                alu_op  = info.alu_op;
                case (info.cls)
                    CLS_BEQ: begin pc_write = aluZero;  pc_src = PC_SRC_BRANCH; end
                    CLS_BNE: begin pc_write = !aluZero; pc_src = PC_SRC_BRANCH; end
                    CLS_J:   begin pc_write = 1'b1;     pc_src = PC_SRC_JUMP;   end
`ifdef MUSA_STACK_OPS_EN
                    CLS_JAL: begin pc_write = 1'b1; pc_src = PC_SRC_JUMP;  push_c = 1'b1; end
                    CLS_RET: begin pc_write = 1'b1; pc_src = PC_SRC_STACK; pop_c  = 1'b1; end
`endif
                    CLS_ILLEGAL: illegal_c = 1'b1;
                    default: ;
                endcase
            end
            ST_MEM: begin
                alu_src   = info.alu_src;
                alu_op    = info.alu_op;
                mem_read  = (info.cls == CLS_LW);
                mem_write = (info.cls == CLS_SW);
            end
            ST_WB: begin
                reg_write  = 1'b1;
                reg_dst    = info.reg_dst;
                mem_to_reg = (info.cls == CLS_LW);
            end
            default: ;
        endcase
        // A stall freezes every side-effecting strobe; select lines keep their values.
        if (stall) begin
            pc_write  = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
            push_c    = 1'b0;
            pop_c     = 1'b0;
            illegal_c = 1'b0;
        end
        if (reset) begin
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            mem_to_reg = 1'b0;
            reg_dst    = 1'b0;
            push_c     = 1'b0;
            pop_c      = 1'b0;
            illegal_c  = 1'b0;
            pc_src     = PC_SRC_INC;
            alu_src    = ALU_SRC_REG;
            alu_op     = ALU_OP_ADD;
        end
    end

    assign stage    = reset ? ST_IF : state_q;
    assign PCWrite  = pc_write;
    assign regWrite = reg_write;
    assign memRead  = mem_read;
    assign memWrite = mem_write;
    assign memToReg = mem_to_reg;
    assign regDst   = reg_dst;
    assign push     = push_c;
    assign pop      = pop_c;
    assign illegal  = illegal_c;
    assign pcSrc    = pc_src;
    assign aluSrc   = alu_src;
    assign aluOp    = ALUOP_W'(alu_op);

endmodule
